// File: rtl/servo_pulse_decoder.sv
// Measures the high time of a servo pulse, converts it to an 8-bit rotation, and flags glitch, range and loss-of-signal errors.
// Latency is at most 258 cycles from the synchronised falling edge to valid. There is no backpressure: strobes last one cycle.
module servo_pulse_decoder #(
    parameter int OFFSET    = 31000,
    parameter int STEP      = 392,
    parameter int MIN_WIDTH = 25000,
    parameter int MAX_WIDTH = 135000,
    parameter int TIMEOUT   = 1100000,
    parameter int CNT_W     = 21
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_pulse_in,
    output logic [7:0] o_rotation,
    output logic       o_valid,
    output logic       o_err_glitch,
    output logic       o_err_range,
    output logic       o_signal_lost,
    output logic       o_busy
);
    localparam logic [CNT_W-1:0] L_OFFSET = CNT_W'(OFFSET);
    localparam logic [CNT_W-1:0] L_STEP   = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] L_MIN    = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] L_MAX    = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] L_TO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_TO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MEASURE, WAIT_LOW, CONVERT} state_t;

    state_t           r_state;
    logic             r_sync1, r_sync2, r_ps_d;
    logic [CNT_W-1:0] r_wcnt, r_tcnt, r_rem;
    logic [7:0]       r_q, r_rotation;
    logic             r_valid, r_glitch, r_range, r_lost;

    logic w_ps, w_rise, w_step, w_done, w_to_hit;

    assign w_ps     = r_sync2;
    assign w_rise   = w_ps & ~r_ps_d;
    assign w_step   = (r_rem >= L_STEP) && (r_q != 8'hFF);
    assign w_done   = i_enable && (r_state == CONVERT) && !w_step;
    assign w_to_hit = i_enable && !w_rise && (r_tcnt == L_TO_M1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_ps_d  <= 1'b0;
        end else begin
            r_sync1 <= i_pulse_in;
            r_sync2 <= r_sync1;
            r_ps_d  <= r_sync2;
        end
    end

    // Loss-of-signal: only a successful decode clears it, never an error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
            r_lost <= 1'b1;
        end else begin
            if (!i_enable || w_rise)
                r_tcnt <= '0;
            else if (r_tcnt != L_TO)
                r_tcnt <= r_tcnt + L_ONE;
            if (w_done)
                r_lost <= 1'b0;
            else if (w_to_hit)
                r_lost <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_wcnt     <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_rotation <= '0;
            r_valid    <= 1'b0;
            r_glitch   <= 1'b0;
            r_range    <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_glitch <= 1'b0;
            r_range  <= 1'b0;
            if (!i_enable) begin
                r_state <= IDLE;
                r_wcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_wcnt  <= L_ONE;
                            r_state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (!w_ps) begin
                            if (r_wcnt < L_MIN) begin
                                r_glitch <= 1'b1;
                                r_state  <= IDLE;
                            end else begin
                                // Widths below OFFSET decode to 0 in one conversion cycle.
                                r_rem   <= (r_wcnt >= L_OFFSET) ? (r_wcnt - L_OFFSET) : '0;
                                r_q     <= '0;
                                r_state <= CONVERT;
                            end
                        end else if (r_wcnt >= L_MAX) begin
                            r_wcnt  <= r_wcnt + L_ONE;
                            r_range <= 1'b1;
                            r_state <= WAIT_LOW;
                        end else begin
                            r_wcnt <= r_wcnt + L_ONE;
                        end
                    end
                    WAIT_LOW: begin
                        if (!w_ps)
                            r_state <= IDLE;
                    end
                    CONVERT: begin
                        if (w_step) begin
                            r_rem <= r_rem - L_STEP;
                            r_q   <= r_q + 8'd1;
                        end else begin
                            r_rotation <= r_q;
                            r_valid    <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_rotation    = r_rotation;
    assign o_valid       = r_valid;
    assign o_err_glitch  = r_glitch;
    assign o_err_range   = r_range;
    assign o_signal_lost = r_lost;
    assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder: a vector table plus hand-written corner sequences, with a strobe scoreboard.
module tb_servo_pulse_decoder;
    localparam int OFFSET = 310, STEP = 4, MINW = 250, MAXW = 1350, TOUT = 11000, CW = 14;
    localparam int K_VALID = 0, K_GLITCH = 1, K_RANGE = 2;

    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pin = 1'b0;
    logic [7:0] rotation;
    logic       valid, err_glitch, err_range, signal_lost, busy;

    servo_pulse_decoder #(.OFFSET(OFFSET), .STEP(STEP), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
                          .TIMEOUT(TOUT), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pulse_in(pin),
        .o_rotation(rotation), .o_valid(valid), .o_err_glitch(err_glitch),
        .o_err_range(err_range), .o_signal_lost(signal_lost), .o_busy(busy));

    initial forever #10 clk = ~clk;

    typedef struct { int kind; logic [7:0] rot; int deadline; } exp_t;
    typedef struct { int width; int kind; logic [7:0] rot; } vec_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, last_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe cycle consumes one expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            int n, kind;
            exp_t e;
            n = int'(valid) + int'(err_glitch) + int'(err_range);
            kind = err_range ? K_RANGE : (err_glitch ? K_GLITCH : K_VALID);
            if (n > 1) begin
                checks++; failures++;
                $display("FAIL strobe_exclusive: got %0d strobes expected 1", n);
            end else if (n == 1) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    if (e.kind == K_VALID) chk("valid_rotation", rotation, e.rot);
                    chk("strobe_in_time", cyc <= e.deadline, 1);
                end
            end else if (sb.size() != 0 && cyc > sb[0].deadline) begin
                e = sb.pop_front();
                checks++; failures++;
                $display("FAIL missing_strobe: got none expected kind %0d by cycle %0d", e.kind, e.deadline);
            end
        end
    end

    task automatic send(input int w, input int kind, input logic [7:0] rot, input bit expect_it);
        exp_t e;
        @(posedge clk); #1;
        last_rise = cyc;
        if (expect_it) begin
            e.kind = kind;
            e.rot  = rot;
            e.deadline = (kind == K_RANGE) ? cyc + MAXW + 4 :
                         (kind == K_GLITCH) ? cyc + w + 4 : cyc + w + 260;
            sb.push_back(e);
        end
        pin = 1'b1;
        repeat (w) @(posedge clk);
        #1 pin = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t vt[14];
        int   target;
        #(20 * 80000);
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt[14];
        int   target;
        vt = '{'{710, K_VALID, 8'd100}, '{710, K_VALID, 8'd100}, '{310, K_VALID, 8'd0},
               '{300, K_VALID, 8'd0},   '{314, K_VALID, 8'd1},   '{313, K_VALID, 8'd0},
               '{1330, K_VALID, 8'd255}, '{1334, K_VALID, 8'd255}, '{100, K_GLITCH, 8'd255},
               '{249, K_GLITCH, 8'd255}, '{250, K_VALID, 8'd0},   '{1350, K_VALID, 8'd255},
               '{1351, K_RANGE, 8'd255}, '{702, K_VALID, 8'd98}};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_rotation", rotation, 0);
        chk("reset_valid", valid, 0);
        chk("reset_glitch", err_glitch, 0);
        chk("reset_range", err_range, 0);
        chk("reset_lost", signal_lost, 1);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        idle(10);

        foreach (vt[i]) begin
            send(vt[i].width, vt[i].kind, vt[i].rot, 1'b1);
            idle(400);
            chk("held_rotation", rotation, vt[i].rot);
            chk("idle_busy", busy, 0);
            if (i == 0) chk("lost_cleared_by_valid", signal_lost, 0);
        end

        // enable dropped mid-measure, raised with the line still high
        @(posedge clk); #1 pin = 1'b1;
        repeat (500) @(posedge clk);
        #1 enable = 1'b0;
        idle(10);
        chk("disabled_busy", busy, 0);
        chk("disabled_rotation", rotation, 98);
        @(posedge clk); #1 enable = 1'b1;
        repeat (300) @(posedge clk);
        #1 pin = 1'b0;
        idle(400);
        chk("no_strobe_after_enable", sb.size(), 0);
        send(710, K_VALID, 8'd100, 1'b1);
        idle(400);
        chk("decode_after_enable", rotation, 100);

        // loss of signal, exactly TOUT cycles after the last synchronised rise
        target = last_rise + 2 + TOUT;
        while (cyc < target) @(negedge clk);
        chk("lost_before_timeout", signal_lost, 0);
        @(negedge clk);
        chk("lost_at_timeout", signal_lost, 1);
        send(310, K_VALID, 8'd0, 1'b1);
        idle(400);
        chk("lost_cleared_again", signal_lost, 0);

        // line stuck high: a single range error, nothing more
        send(2000, K_RANGE, 8'd0, 1'b1);
        idle(400);
        chk("stuck_high_rotation", rotation, 0);
        send(710, K_VALID, 8'd100, 1'b1);
        idle(400);

        // asynchronous reset while converting
        send(1330, K_VALID, 8'd0, 1'b0);
        idle(100);
        chk("busy_in_convert", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rotation", rotation, 0);
        chk("arst_valid", valid, 0);
        chk("arst_lost", signal_lost, 1);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(400);
        chk("no_valid_after_reset", rotation, 0);
        chk("lost_after_reset", signal_lost, 1);
        send(710, K_VALID, 8'd100, 1'b1);
        idle(400);
        chk("decode_after_reset", rotation, 100);
        chk("lost_cleared_after_reset", signal_lost, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/servo_pulse_decoder.md
Name: servo_pulse_decoder

Overview:
- Receive-side counterpart of the servo PWM driver. Measures the high time of an incoming servo-style pulse (e.g. RC receiver, or loopback from the driver) on a 50 MHz clock.
- Converts the measured width back to an 8-bit rotation value using the same mapping the driver uses: width = OFFSET + rotation*STEP.
- Sits between an external pulse pin and control logic. Also reports glitches, out-of-range pulses and loss of signal.

Parameters:
- OFFSET, 31000, width in clk cycles that maps to rotation 0
- STEP, 392, clk cycles per rotation LSB
- MIN_WIDTH, 25000, shorter high time is a glitch
- MAX_WIDTH, 135000, longer high time is out of range
- TIMEOUT, 1100000, clk cycles without a rising edge before signal_lost asserts
- CNT_W, 21, width of the width and timeout counters; must hold TIMEOUT+1

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  decoder enable
- pulse_in  in  1  asynchronous servo pulse input
- rotation  out  8  last decoded rotation, held between updates
- valid  out  1  one-cycle strobe; rotation updated this cycle
- err_glitch  out  1  one-cycle strobe; pulse shorter than MIN_WIDTH
- err_range  out  1  one-cycle strobe; pulse longer than MAX_WIDTH
- signal_lost  out  1  level; no rising edge for TIMEOUT cycles
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: rotation=0, valid=0, err_glitch=0, err_range=0, busy=0, signal_lost=1, state=IDLE, all counters 0, synchroniser flops 0.
- Input conditioning: pulse_in passes through a 2-FF synchroniser. Edges are detected on the synchronised signal ps, comparing ps to its previous value.
- Width w is the number of clk cycles ps is high.
- States and transitions:
  - IDLE. On a ps rising edge: wcnt=1, go to MEASURE. A line already high on entry to IDLE (no edge seen) is ignored.
  - MEASURE. While ps=1: wcnt++.
    - If wcnt would exceed MAX_WIDTH: pulse err_range, go to WAIT_LOW.
    - On ps falling edge: if w<MIN_WIDTH, pulse err_glitch and go to IDLE; else go to CONVERT.
  - WAIT_LOW. Go to IDLE when ps=0. No strobes.
  - CONVERT. Sequential restoring division, one subtraction per cycle.
    - If w<OFFSET: result is 0 (needs at most 1 cycle).
    - Otherwise rem=w-OFFSET, q=0. While rem>=STEP and q<255: rem-=STEP, q++.
    - On completion: rotation<=q, valid=1 for one cycle, go to IDLE.
    - Worst-case latency is 258 cycles from the synchronised falling edge to valid.
    - A rising edge during CONVERT is not measured; that pulse is lost.
- Clamping: a result above 255 clamps to 255 with no error. MIN_WIDTH <= w < OFFSET decodes to 0.
- Timeout:
  - tcnt clears on every ps rising edge and otherwise increments, saturating at TIMEOUT.
  - signal_lost sets when tcnt reaches TIMEOUT.
  - signal_lost clears only on a valid strobe. Glitches and range errors do not clear it.
- Strobe exclusivity: valid, err_glitch and err_range are mutually exclusive and each lasts exactly 1 cycle.
- enable=0:
  - Synchronous return to IDLE; any measurement or conversion is abandoned.
  - wcnt and tcnt are held at 0; no strobes.
  - rotation and signal_lost are held.
  - After enable rises, decoding starts at the next rising edge.
- Reset mid-operation: async return to the reset values immediately, including signal_lost=1.

Test Plan:
- Reset, then 20 ms period pulses of width 70200 cycles -> valid once per pulse, ≤258 cycles after the falling edge; rotation=100; signal_lost falls on the first valid.
- Width 31000 -> rotation=0. Width 30000 -> rotation=0, valid. Width 130960 -> rotation=255. Width 131500 -> rotation=255 (clamped), no error.
- Width 1000 -> err_glitch for 1 cycle, no valid, rotation unchanged. Line held high for 200000 cycles -> err_range once at wcnt=MAX_WIDTH+1; no further strobes until the line goes low and a new pulse arrives.
- Stop pulses after one valid decode -> signal_lost rises exactly TIMEOUT cycles after the last synchronised rising edge; next valid pulse clears it.
- Drop enable mid-MEASURE, then raise it with the line still high -> no strobes for that pulse; the next full pulse decodes correctly.
- Assert rst_n=0 during CONVERT -> all outputs return to reset values immediately with no clk edge; no valid after release until a new full pulse.
